// File: rtl/mux_sel_sequencer_pkg.sv
// Shared definitions for mux_sel_sequencer: FSM encodings and the latency/level-count helpers
// that must agree with mux_fixed_pipeline.
package mux_sel_sequencer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StHold = 2'd1;
    localparam state_t StDone = 2'd2;

    function automatic int unsigned sel_width(int unsigned input_count);
        return (input_count <= 1) ? 1 : $clog2(input_count);
    endfunction

    // Mux levels = ceil(sel bits / sel bits resolved per level).
    function automatic int unsigned mux_levels(int unsigned sel_w, int unsigned mux_size);
        int unsigned lvl_bits;
        lvl_bits = (mux_size <= 2) ? 1 : $clog2(mux_size);
        return (sel_w + lvl_bits - 1) / lvl_bits;
    endfunction

endpackage

// File: rtl/mux_sel_sequencer_if.sv
// Channel-side and mux-side signals of mux_sel_sequencer; master is the sequencer,
// slave is the requesters plus the pipelined mux.
interface mux_sel_sequencer_if
    import mux_sel_sequencer_pkg::*;
#(
    parameter int unsigned INPUT_COUNT = 10,
    parameter int unsigned SEL_W       = sel_width(INPUT_COUNT)
);
    logic [INPUT_COUNT-1:0] req;
    logic [SEL_W-1:0]       sel;
    logic [INPUT_COUNT-1:0] ack;
    logic                   out_valid;
    logic [SEL_W-1:0]       out_sel;
    logic                   busy;

    modport master (
        input  req,
        output sel,
        output ack,
        output out_valid,
        output out_sel,
        output busy
    );

    modport slave (
        output req,
        input  sel,
        input  ack,
        input  out_valid,
        input  out_sel,
        input  busy
    );
endinterface

// File: rtl/mux_sel_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester strictly after ptr,
// wrapping from N-1 to 0, and returns it as one-hot grant plus index.
module mux_sel_sequencer_rr_arbiter #(
    parameter int unsigned N     = 10,
    parameter int unsigned IDX_W = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Two passes keep every req index constant: first the channels above ptr, then the wrap.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (!valid && req[i] && (IDX_W'(i) > ptr)) begin
                valid    = 1'b1;
                idx      = IDX_W'(i);
                grant[i] = 1'b1;
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            if (!valid && req[i] && (IDX_W'(i) <= ptr)) begin
                valid    = 1'b1;
                idx      = IDX_W'(i);
                grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Arbitrating sel sequencer for a pipelined mux: holds sel for the mux latency, then pulses
// out_valid/ack. Define MUX_SEQ_FIXED_PRIORITY_EN for fixed lowest-index-wins priority.
module mux_sel_sequencer
    import mux_sel_sequencer_pkg::*;
#(
    parameter int unsigned INPUT_COUNT = 10,
    parameter int unsigned MUX_SIZE    = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    mux_sel_sequencer_if.master bus
);

    localparam int unsigned SEL_W   = sel_width(INPUT_COUNT);
    localparam int unsigned LATENCY = mux_levels(SEL_W, MUX_SIZE);
    localparam int unsigned CNT_W   = $clog2(LATENCY + 1);

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [SEL_W-1:0]       out_sel_q, out_sel_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [INPUT_COUNT-1:0] gnt_oh_q, gnt_oh_d;
    logic [INPUT_COUNT-1:0] ack_q, ack_d;
    logic                   out_valid_q, out_valid_d;

    logic [SEL_W-1:0]       ptr;
    logic [INPUT_COUNT-1:0] arb_grant;
    logic [SEL_W-1:0]       arb_idx;
    logic                   arb_valid;
    logic                   grant_now;

    assign grant_now = (state_q == StIdle) && arb_valid;

`ifdef MUX_SEQ_FIXED_PRIORITY_EN
    // Pointer pinned to the last channel so the scan always starts at channel 0.
    assign ptr = SEL_W'(INPUT_COUNT - 1);
`else
    logic [SEL_W-1:0] ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= SEL_W'(INPUT_COUNT - 1);
        end else if (grant_now) begin
            ptr_q <= arb_idx;
        end
    end

    assign ptr = ptr_q;
`endif

    mux_sel_sequencer_rr_arbiter #(
        .N     (INPUT_COUNT),
        .IDX_W (SEL_W)
    ) u_arb (
        .req   (bus.req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        out_sel_d   = out_sel_q;
        cnt_d       = cnt_q;
        gnt_oh_d    = gnt_oh_q;
        ack_d       = '0;
        out_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    sel_d    = arb_idx;
                    gnt_oh_d = arb_grant;
                    cnt_d    = CNT_W'(LATENCY);
                    state_d  = StHold;
                end
            end
            StHold: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = StDone;
                    out_valid_d = 1'b1;
                    ack_d       = gnt_oh_q;
                    out_sel_d   = sel_q;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sel_q       <= '0;
            out_sel_q   <= '0;
            cnt_q       <= '0;
            gnt_oh_q    <= '0;
            ack_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            out_sel_q   <= out_sel_d;
            cnt_q       <= cnt_d;
            gnt_oh_q    <= gnt_oh_d;
            ack_q       <= ack_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.ack       = ack_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scoreboard bench for mux_sel_sequencer with a behavioural 4-level mux (in[i]=i) on sel.
module tb_mux_sel_sequencer;

    localparam int N   = 10;
    localparam int LAT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mux_sel_sequencer_if #(.INPUT_COUNT(N)) bus ();

    mux_sel_sequencer #(
        .INPUT_COUNT (N),
        .MUX_SIZE    (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   cyc      = 0;
    int   last_ov  = 0;
    int   base     = 0;
    bit   period_chk = 1'b0;
    bit   have_last  = 1'b0;
    logic prev_busy  = 1'b0;
    logic [3:0] hold_sel = '0;
    int   exp_q[$];
    logic [3:0] mux_pipe [LAT];

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endfunction

    // Mux model: one level per edge, so data for sel granted at edge k appears after edge k+4.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        mux_pipe[0] <= bus.sel;
        for (int k = 1; k < LAT; k++) mux_pipe[k] <= mux_pipe[k-1];
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 1'b0;
        end else begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check("out_sel", int'(bus.out_sel), e);
                    check("ack", int'(bus.ack), 1 << e);
                    check("mux_out", int'(mux_pipe[LAT-1]), e);
                    if (period_chk && have_last) check("period", cyc - last_ov, LAT + 2);
                    last_ov   = cyc;
                    have_last = 1'b1;
                end
                n_done++;
            end else begin
                check("ack_idle", int'(bus.ack), 0);
            end
            if (bus.busy && prev_busy) check("sel_hold", int'(bus.sel), int'(hold_sel));
            else if (bus.busy) hold_sel = bus.sel;
            prev_busy = bus.busy;
        end
    end

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (n_done < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (n_done < target) check("timeout", n_done, target);
    endtask

    task automatic do_reset();
        bus.req    = '0;
        rst_n      = 1'b0;
        period_chk = 1'b0;
        have_last  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic settle();
        repeat (LAT + 4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("idle_busy", int'(bus.busy), 0);
    endtask

    initial begin
        bus.req = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_sel", int'(bus.sel), 0);
        check("rst_out_sel", int'(bus.out_sel), 0);
        check("rst_ack", int'(bus.ack), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single request: grant at edge 1, out_valid only after edge 5.
        @(negedge clk);
        bus.req = 10'h004;
        exp_q.push_back(2);
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            if (j == 1) check("t1_sel", int'(bus.sel), 2);
            check("t1_out_valid", int'(bus.out_valid), int'(j == 5));
            if (j == 5) begin
                check("t1_ack", int'(bus.ack), 4);
                bus.req = '0;
            end
        end
        check("t1_busy", int'(bus.busy), 0);

        // All requesting: rotation 0..9,0 with a 6-cycle period.
        do_reset();
        period_chk = 1'b1;
        for (int i = 0; i <= N; i++) begin
`ifdef MUX_SEQ_FIXED_PRIORITY_EN
            exp_q.push_back(0);
`else
            exp_q.push_back(i % N);
`endif
        end
        base = n_done;
        bus.req = 10'h3FF;
        wait_done(base + N + 1, (N + 1) * (LAT + 2) + 20);
        bus.req = '0;
        settle();

        // ch0 drops after its ack; ch9 then repeats alone.
        do_reset();
        exp_q.push_back(0);
        exp_q.push_back(9);
        exp_q.push_back(9);
        exp_q.push_back(9);
        base = n_done;
        bus.req = 10'h201;
        wait_done(base + 1, 20);
        bus.req[0] = 1'b0;
        wait_done(base + 4, 40);
        bus.req = '0;
        settle();

        // req dropped mid-HOLD: transfer still completes, no further grant.
        do_reset();
        exp_q.push_back(4);
        base = n_done;
        bus.req = 10'h010;
        repeat (3) @(negedge clk);
        check("t4_busy_in_hold", int'(bus.busy), 1);
        bus.req = '0;
        wait_done(base + 1, 20);
        settle();

        // Reset mid-HOLD aborts the transfer; first grant after release is the lowest requester.
        do_reset();
        exp_q.push_back(3);
        base = n_done;
        bus.req = 10'h0C8;
        wait_done(base + 1, 20);
        repeat (3) @(negedge clk);
`ifdef MUX_SEQ_FIXED_PRIORITY_EN
        check("t5_sel_before_reset", int'(bus.sel), 3);
`else
        check("t5_sel_before_reset", int'(bus.sel), 6);
`endif
        rst_n = 1'b0;
        #1;
        check("t5_sel", int'(bus.sel), 0);
        check("t5_out_sel", int'(bus.out_sel), 0);
        check("t5_ack", int'(bus.ack), 0);
        check("t5_out_valid", int'(bus.out_valid), 0);
        check("t5_busy", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
        exp_q.push_back(3);
        rst_n = 1'b1;
        wait_done(base + 2, 20);
        bus.req = '0;
        settle();

        // Two high channels: alternate under round-robin, always 8 under fixed priority.
        do_reset();
        exp_q.push_back(8);
`ifdef MUX_SEQ_FIXED_PRIORITY_EN
        exp_q.push_back(8);
`else
        exp_q.push_back(9);
`endif
        exp_q.push_back(8);
        base = n_done;
        bus.req = 10'h300;
        wait_done(base + 3, 40);
        bus.req = '0;
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
